// File: rtl/lsu_split.sv
// lsu_split: memory-stage load/store unit driving a variable-latency req/ack
// word bus. Word-crossing accesses are split into two aligned beats (or
// trapped when ALLOW_MISALIGN=0). Bus errors and timeouts become access faults.
//
// Handshakes:
//   ex_mb: an access is taken in IDLE on the edge where ex_mb__valid and
//          (read|write) are high; while mb_ex__stall is high the producer holds
//          every ex_mb__* input stable. mb_wb__valid is a one-cycle pulse.
//   bus:   bus_req/we/addr/wstrb/wdata are registered and stay stable until a
//          rising edge samples bus_ack high with bus_req; bus_err/bus_rdata are
//          only looked at on that edge.
module lsu_split #(
  parameter int ADDR_W         = 32,
  parameter bit ALLOW_MISALIGN = 1'b1,
  parameter int TIMEOUT        = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_mb__valid,
  input  logic [ADDR_W-1:0] ex_mb__addr,
  input  logic [31:0]       ex_mb__wdata,
  input  logic [1:0]        ex_mb__width,
  input  logic              ex_mb__zero_ext,
  input  logic              ex_mb__read,
  input  logic              ex_mb__write,
  output logic              mb_ex__stall,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [3:0]        bus_wstrb,
  output logic [31:0]       bus_wdata,
  input  logic              bus_ack,
  input  logic              bus_err,
  input  logic [31:0]       bus_rdata,
  output logic              mb_wb__valid,
  output logic [31:0]       mb_wb__rdata,
  output logic              mb_wb__load_misalign,
  output logic              mb_wb__store_misalign,
  output logic              mb_wb__access_fault
);

  localparam logic [1:0] ENCDEC_BYTE = 2'd0;
  localparam logic [1:0] ENCDEC_HALF = 2'd1;
  localparam logic [1:0] ENCDEC_WORD = 2'd2;

  localparam int             CNT_W    = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, RESP} state_t;

  state_t state_q, state_d;

  logic        access;
  logic        crossing;
  logic [1:0]  off;
  logic [3:0]  width_mask;
  logic [7:0]  strb_wide;
  logic [63:0] wdata_wide;
  logic        beat_done;

  // Captured access attributes, valid from acceptance until RESP.
  logic [1:0]       off_q;
  logic [1:0]       width_q;
  logic             zext_q;
  logic             read_q;
  logic             cross_q;
  logic [3:0]       strb_hi_q;
  logic [31:0]      wdata_hi_q;
  logic [31:0]      rbuf_q;
  logic [CNT_W-1:0] cnt_q;

  // Select the addressed bytes from {beat1, beat0} and extend to 32 bits.
  function automatic logic [31:0] load_extend(input logic [63:0] raw,
                                              input logic [1:0]  o,
                                              input logic [1:0]  w,
                                              input logic        z);
    logic [31:0] sh;
    sh = 32'(raw >> {o, 3'b000});
    case (w)
      ENCDEC_BYTE: load_extend = {{24{~z & sh[7]}}, sh[7:0]};
      ENCDEC_HALF: load_extend = {{16{~z & sh[15]}}, sh[15:0]};
      default:     load_extend = sh;
    endcase
  endfunction

  // Decode the presented access: crossing check and lane-shifted strobe/data.
  always_comb begin
    access     = ex_mb__valid && (ex_mb__read || ex_mb__write);
    off        = ex_mb__addr[1:0];
    width_mask = 4'b1111;
    case (ex_mb__width)
      ENCDEC_BYTE: width_mask = 4'b0001;
      ENCDEC_HALF: width_mask = 4'b0011;
      default:     width_mask = 4'b1111;
    endcase
    crossing   = ((ex_mb__width == ENCDEC_HALF) && (off == 2'd3)) ||
                 ((ex_mb__width != ENCDEC_BYTE) && (ex_mb__width != ENCDEC_HALF) &&
                  (off != 2'd0));
    strb_wide  = {4'b0000, width_mask} << off;
    wdata_wide = {32'h0, ex_mb__wdata} << {off, 3'b000};
    beat_done  = bus_req && bus_ack;
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state and combinational stall; ack always beats an expiring timeout.
  always_comb begin
    state_d      = state_q;
    mb_ex__stall = 1'b0;
    case (state_q)
      IDLE: begin
        mb_ex__stall = access;
        if (access) state_d = (crossing && !ALLOW_MISALIGN) ? RESP : BEAT0;
      end
      BEAT0: begin
        mb_ex__stall = 1'b1;
        if (beat_done)             state_d = (cross_q && !bus_err) ? BEAT1 : RESP;
        else if (cnt_q == CNT_LAST) state_d = RESP;
      end
      BEAT1: begin
        mb_ex__stall = 1'b1;
        if (beat_done || (cnt_q == CNT_LAST)) state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Response pulse is simply the RESP state.
  always_comb begin
    mb_wb__valid = (state_q == RESP);
  end

  // Bus registers, beat sequencing, timeout counter and response capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus_req               <= 1'b0;
      bus_we                <= 1'b0;
      bus_addr              <= '0;
      bus_wstrb             <= 4'h0;
      bus_wdata             <= 32'h0;
      mb_wb__rdata          <= 32'h0;
      mb_wb__load_misalign  <= 1'b0;
      mb_wb__store_misalign <= 1'b0;
      mb_wb__access_fault   <= 1'b0;
      off_q                 <= 2'd0;
      width_q               <= 2'd0;
      zext_q                <= 1'b0;
      read_q                <= 1'b0;
      cross_q               <= 1'b0;
      strb_hi_q             <= 4'h0;
      wdata_hi_q            <= 32'h0;
      rbuf_q                <= 32'h0;
      cnt_q                 <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (access) begin
            off_q                 <= off;
            width_q               <= ex_mb__width;
            zext_q                <= ex_mb__zero_ext;
            read_q                <= ex_mb__read;
            cross_q               <= crossing;
            mb_wb__rdata          <= 32'h0;
            mb_wb__access_fault   <= 1'b0;
            mb_wb__load_misalign  <= 1'b0;
            mb_wb__store_misalign <= 1'b0;
            cnt_q                 <= '0;
            if (crossing && !ALLOW_MISALIGN) begin
              mb_wb__load_misalign  <= ex_mb__read;
              mb_wb__store_misalign <= !ex_mb__read;
            end else begin
              bus_req    <= 1'b1;
              bus_we     <= !ex_mb__read;
              bus_addr   <= {ex_mb__addr[ADDR_W-1:2], 2'b00};
              bus_wstrb  <= ex_mb__read ? 4'h0 : strb_wide[3:0];
              bus_wdata  <= wdata_wide[31:0];
              strb_hi_q  <= ex_mb__read ? 4'h0 : strb_wide[7:4];
              wdata_hi_q <= wdata_wide[63:32];
            end
          end
        end
        BEAT0, BEAT1: begin
          if (beat_done) begin
            cnt_q <= '0;
            if (bus_err) begin
              bus_req             <= 1'b0;
              mb_wb__access_fault <= 1'b1;
              mb_wb__rdata        <= 32'h0;
            end else if ((state_q == BEAT0) && cross_q) begin
              bus_addr  <= bus_addr + ADDR_W'(4);
              bus_wstrb <= strb_hi_q;
              bus_wdata <= wdata_hi_q;
              rbuf_q    <= bus_rdata;
            end else begin
              bus_req <= 1'b0;
              if (!read_q)
                mb_wb__rdata <= 32'h0;
              else if (state_q == BEAT1)
                mb_wb__rdata <= load_extend({bus_rdata, rbuf_q}, off_q, width_q, zext_q);
              else
                mb_wb__rdata <= load_extend({32'h0, bus_rdata}, off_q, width_q, zext_q);
            end
          end else if (cnt_q == CNT_LAST) begin
            bus_req             <= 1'b0;
            mb_wb__access_fault <= 1'b1;
            mb_wb__rdata        <= 32'h0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_split.sv
// tb_lsu_split: table-driven bench for lsu_split. One instance splits
// misaligned accesses (short timeout), a second instance traps them.
module tb_lsu_split;

  localparam int         AW  = 32;
  localparam int         TMO = 4;
  localparam logic [1:0] W_B = 2'd0;
  localparam logic [1:0] W_H = 2'd1;
  localparam logic [1:0] W_W = 2'd2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // ---------------- stimulus signals ----------------
  logic          ex_valid, ex_valid_t;
  logic [AW-1:0] ex_addr;
  logic [31:0]   ex_wdata;
  logic [1:0]    ex_width;
  logic          ex_zext, ex_read, ex_write;
  logic          bus_ack, bus_err;
  logic [31:0]   bus_rdata;
  logic          t_ack, t_err;
  logic [31:0]   t_rdata;
  logic          use_trap;

  logic          d_stall, d_req, d_we, d_valid, d_lmis, d_smis, d_fault;
  logic [AW-1:0] d_addr;
  logic [3:0]    d_strb;
  logic [31:0]   d_wdata, d_rdata;
  logic          t_stall, t_req, t_we, t_valid, t_lmis, t_smis, t_fault;
  logic [AW-1:0] t_addr;
  logic [3:0]    t_strb;
  logic [31:0]   t_wdata, t_rdata_o;

  lsu_split #(.ADDR_W(AW), .ALLOW_MISALIGN(1'b1), .TIMEOUT(TMO)) u_dut (
    .clk(clk), .rst(rst),
    .ex_mb__valid(ex_valid), .ex_mb__addr(ex_addr), .ex_mb__wdata(ex_wdata),
    .ex_mb__width(ex_width), .ex_mb__zero_ext(ex_zext), .ex_mb__read(ex_read),
    .ex_mb__write(ex_write), .mb_ex__stall(d_stall),
    .bus_req(d_req), .bus_we(d_we), .bus_addr(d_addr), .bus_wstrb(d_strb),
    .bus_wdata(d_wdata), .bus_ack(bus_ack), .bus_err(bus_err), .bus_rdata(bus_rdata),
    .mb_wb__valid(d_valid), .mb_wb__rdata(d_rdata),
    .mb_wb__load_misalign(d_lmis), .mb_wb__store_misalign(d_smis),
    .mb_wb__access_fault(d_fault)
  );

  lsu_split #(.ADDR_W(AW), .ALLOW_MISALIGN(1'b0), .TIMEOUT(16)) u_trap (
    .clk(clk), .rst(rst),
    .ex_mb__valid(ex_valid_t), .ex_mb__addr(ex_addr), .ex_mb__wdata(ex_wdata),
    .ex_mb__width(ex_width), .ex_mb__zero_ext(ex_zext), .ex_mb__read(ex_read),
    .ex_mb__write(ex_write), .mb_ex__stall(t_stall),
    .bus_req(t_req), .bus_we(t_we), .bus_addr(t_addr), .bus_wstrb(t_strb),
    .bus_wdata(t_wdata), .bus_ack(t_ack), .bus_err(t_err), .bus_rdata(t_rdata),
    .mb_wb__valid(t_valid), .mb_wb__rdata(t_rdata_o),
    .mb_wb__load_misalign(t_lmis), .mb_wb__store_misalign(t_smis),
    .mb_wb__access_fault(t_fault)
  );

  // Observed outputs of whichever instance the current vector targets.
  logic          s_stall, s_req, s_we, s_valid;
  logic [AW-1:0] s_addr;
  logic [3:0]    s_strb;
  logic [31:0]   s_wdata;
  logic [34:0]   s_resp;
  assign s_stall = use_trap ? t_stall : d_stall;
  assign s_req   = use_trap ? t_req   : d_req;
  assign s_we    = use_trap ? t_we    : d_we;
  assign s_valid = use_trap ? t_valid : d_valid;
  assign s_addr  = use_trap ? t_addr  : d_addr;
  assign s_strb  = use_trap ? t_strb  : d_strb;
  assign s_wdata = use_trap ? t_wdata : d_wdata;
  assign s_resp  = use_trap ? {t_fault, t_lmis, t_smis, t_rdata_o}
                            : {d_fault, d_lmis, d_smis, d_rdata};

  // ---------------- scoreboard ----------------
  logic [34:0] exp_q[$];   // {access_fault, load_misalign, store_misalign, rdata}
  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [34:0] rsp(input bit f, input bit lm, input bit sm,
                                      input logic [31:0] d);
    rsp = {f, lm, sm, d};
  endfunction

  // ---------------- vector table ----------------
  typedef struct {
    string       name;
    bit          trap;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  width;
    bit          zext;
    bit          rd;
    bit          wr;
    logic [31:0] rd0;
    logic [31:0] rd1;
    int          wait_n;   // wait cycles before each ack; 99 = never ack
    int          err_beat; // 0 none, 1 = err on beat0, 2 = err on beat1
    logic [31:0] a0;
    logic [3:0]  s0;
    logic [31:0] d0;
    logic [31:0] a1;
    logic [3:0]  s1;
    logic [31:0] d1;
    int          beats;
    int          lat;      // edges from acceptance to the response pulse
    logic [34:0] resp;
  } vec_t;

  function automatic vec_t mk(input string nm, input bit trap, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [1:0] w, input bit zext,
                              input bit rd, input bit wr, input logic [31:0] rd0,
                              input logic [31:0] rd1, input int wt, input int eb,
                              input logic [31:0] a0, input logic [3:0] s0, input logic [31:0] d0,
                              input logic [31:0] a1, input logic [3:0] s1, input logic [31:0] d1,
                              input int beats, input int lat, input logic [34:0] resp);
    vec_t v;
    v.name = nm; v.trap = trap; v.addr = addr; v.wdata = wdata; v.width = w;
    v.zext = zext; v.rd = rd; v.wr = wr; v.rd0 = rd0; v.rd1 = rd1;
    v.wait_n = wt; v.err_beat = eb; v.a0 = a0; v.s0 = s0; v.d0 = d0;
    v.a1 = a1; v.s1 = s1; v.d1 = d1; v.beats = beats; v.lat = lat; v.resp = resp;
    mk = v;
  endfunction

  // ---------------- driver ----------------
  task automatic run_vec(input vec_t v);
    int cyc, beat, issued, wcnt, reqc, stallc;
    bit done;
    logic [34:0] exp_r;
    @(posedge clk); #1;
    use_trap = v.trap;
    ex_addr  = v.addr;  ex_wdata = v.wdata; ex_width = v.width;
    ex_zext  = v.zext;  ex_read  = v.rd;    ex_write = v.wr;
    if (v.trap) ex_valid_t = 1'b1;
    else        ex_valid   = 1'b1;
    exp_q.push_back(v.resp);
    #1 chk({v.name, "_stall_present"}, 64'(s_stall), 64'(1));
    cyc = 0; beat = 0; issued = 0; wcnt = 0; reqc = 0; stallc = 0; done = 0;
    while (!done && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
      bus_ack = 1'b0; bus_err = 1'b0; bus_rdata = 32'h0;
      if (s_valid) begin
        done       = 1'b1;
        ex_valid   = 1'b0;
        ex_valid_t = 1'b0;
        chk({v.name, "_latency"}, 64'(cyc - 1), 64'(v.lat));
        chk({v.name, "_stall_resp"}, 64'(s_stall), 64'(0));
        exp_r = exp_q.pop_front();
        chk({v.name, "_resp"}, 64'(s_resp), 64'(exp_r));
      end else begin
        if (s_stall) stallc++;
        if (s_req) begin
          reqc++;
          if (wcnt == 0) begin
            issued++;
            if (beat == 0) begin
              chk({v.name, "_b0_addr"}, 64'(s_addr), 64'(v.a0));
              chk({v.name, "_b0_strb"}, 64'(s_strb), 64'(v.s0));
              chk({v.name, "_b0_we"}, 64'(s_we), 64'(v.wr));
              if (v.wr) chk({v.name, "_b0_wdata"}, 64'(s_wdata), 64'(v.d0));
            end else begin
              chk({v.name, "_b1_addr"}, 64'(s_addr), 64'(v.a1));
              chk({v.name, "_b1_strb"}, 64'(s_strb), 64'(v.s1));
              if (v.wr) chk({v.name, "_b1_wdata"}, 64'(s_wdata), 64'(v.d1));
            end
          end
          if (wcnt == v.wait_n) begin
            bus_ack   = 1'b1;
            bus_err   = (v.err_beat == beat + 1);
            bus_rdata = (beat == 0) ? v.rd0 : v.rd1;
            beat++;
            wcnt = 0;
          end else begin
            wcnt++;
          end
        end
      end
    end
    bus_ack = 1'b0; bus_err = 1'b0;
    if (!done) begin
      n_checks++; n_fail++;
      $display("FAIL %s_no_response actual=none expected=valid within 40 cycles", v.name);
      ex_valid = 1'b0; ex_valid_t = 1'b0;
      void'(exp_q.pop_front());
    end
    chk({v.name, "_beats"}, 64'(issued), 64'(v.beats));
    chk({v.name, "_req_cycles"}, 64'(reqc), 64'(v.lat));
    chk({v.name, "_stall_cycles"}, 64'(stallc), 64'(v.lat));
  endtask

  // ---------------- test sequence ----------------
  vec_t vecs[$];

  initial begin
    rst = 1'b1; use_trap = 1'b0;
    ex_valid = 1'b0; ex_valid_t = 1'b0; ex_addr = '0; ex_wdata = '0;
    ex_width = W_W; ex_zext = 1'b0; ex_read = 1'b0; ex_write = 1'b0;
    bus_ack = 1'b0; bus_err = 1'b0; bus_rdata = '0;
    t_ack = 1'b0; t_err = 1'b0; t_rdata = '0;

    // Reset state, applied before any clock edge.
    #1;
    chk("rst_bus_req", 64'(d_req), 64'(0));
    chk("rst_valid", 64'(d_valid), 64'(0));
    chk("rst_resp", 64'({d_fault, d_lmis, d_smis, d_rdata}), 64'(0));
    chk("rst_trap_valid", 64'(t_valid), 64'(0));
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    //            name              trap addr          wdata         w    z  rd wr rd0           rd1           wt  eb a0            s0     d0            a1            s1     d1            bt lat resp
    vecs.push_back(mk("ld_w_aligned", 0, 32'h100,      32'h0,        W_W, 0, 1, 0, 32'hDEADBEEF, 32'h0,        0,  0, 32'h100,      4'h0, 32'h0,        32'h0,        4'h0, 32'h0,        1, 1, rsp(0,0,0,32'hDEADBEEF)));
    vecs.push_back(mk("ld_b_sext",    0, 32'h103,      32'h0,        W_B, 0, 1, 0, 32'h80000000, 32'h0,        0,  0, 32'h100,      4'h0, 32'h0,        32'h0,        4'h0, 32'h0,        1, 1, rsp(0,0,0,32'hFFFFFF80)));
    vecs.push_back(mk("ld_b_zext",    0, 32'h103,      32'h0,        W_B, 1, 1, 0, 32'h80000000, 32'h0,        0,  0, 32'h100,      4'h0, 32'h0,        32'h0,        4'h0, 32'h0,        1, 1, rsp(0,0,0,32'h00000080)));
    vecs.push_back(mk("st_w_split",   0, 32'h202,      32'hAABBCCDD, W_W, 0, 0, 1, 32'h0,        32'h0,        0,  0, 32'h200,      4'hC, 32'hCCDD0000, 32'h204,      4'h3, 32'h0000AABB, 2, 2, rsp(0,0,0,32'h0)));
    vecs.push_back(mk("ld_h_split",   0, 32'h3FF,      32'h0,        W_H, 0, 1, 0, 32'h12556677, 32'h99887734, 0,  0, 32'h3FC,      4'h0, 32'h0,        32'h400,      4'h0, 32'h0,        2, 2, rsp(0,0,0,32'h00003412)));
    vecs.push_back(mk("ld_h_wrap",    0, 32'hFFFFFFFF, 32'h0,        W_H, 0, 1, 0, 32'hC3000000, 32'h00000085, 0,  0, 32'hFFFFFFFC, 4'h0, 32'h0,        32'h0,        4'h0, 32'h0,        2, 2, rsp(0,0,0,32'hFFFF85C3)));
    vecs.push_back(mk("st_h_wait2",   0, 32'h102,      32'h1234ABCD, W_H, 0, 0, 1, 32'h0,        32'h0,        2,  0, 32'h100,      4'hC, 32'hABCD0000, 32'h0,        4'h0, 32'h0,        1, 3, rsp(0,0,0,32'h0)));
    vecs.push_back(mk("st_b_wait1",   0, 32'h301,      32'h0000005A, W_B, 0, 0, 1, 32'h0,        32'h0,        1,  0, 32'h300,      4'h2, 32'h00005A00, 32'h0,        4'h0, 32'h0,        1, 2, rsp(0,0,0,32'h0)));
    vecs.push_back(mk("ld_w_split_w", 0, 32'h501,      32'h0,        W_W, 0, 1, 0, 32'h33221100, 32'hFFFFFF44, 1,  0, 32'h500,      4'h0, 32'h0,        32'h504,      4'h0, 32'h0,        2, 4, rsp(0,0,0,32'h44332211)));
    vecs.push_back(mk("ld_h_zext",    0, 32'h402,      32'h0,        W_H, 1, 1, 0, 32'h80011234, 32'h0,        0,  0, 32'h400,      4'h0, 32'h0,        32'h0,        4'h0, 32'h0,        1, 1, rsp(0,0,0,32'h00008001)));
    vecs.push_back(mk("ld_timeout",   0, 32'h600,      32'h0,        W_W, 0, 1, 0, 32'h0,        32'h0,        99, 0, 32'h600,      4'h0, 32'h0,        32'h0,        4'h0, 32'h0,        1, TMO, rsp(1,0,0,32'h0)));
    vecs.push_back(mk("ld_ack_expiry",0, 32'h800,      32'h0,        W_W, 0, 1, 0, 32'h0BADF00D, 32'h0,        TMO-1, 0, 32'h800,   4'h0, 32'h0,        32'h0,        4'h0, 32'h0,        1, TMO, rsp(0,0,0,32'h0BADF00D)));
    vecs.push_back(mk("st_err_beat0", 0, 32'h203,      32'h11223344, W_W, 0, 0, 1, 32'h0,        32'h0,        0,  1, 32'h200,      4'h8, 32'h44000000, 32'h0,        4'h0, 32'h0,        1, 1, rsp(1,0,0,32'h0)));
    vecs.push_back(mk("ld_err_align", 0, 32'h700,      32'h0,        W_W, 0, 1, 0, 32'hFFFFFFFF, 32'h0,        0,  1, 32'h700,      4'h0, 32'h0,        32'h0,        4'h0, 32'h0,        1, 1, rsp(1,0,0,32'h0)));
    vecs.push_back(mk("ld_err_beat1", 0, 32'h3FE,      32'h0,        W_W, 0, 1, 0, 32'h55667788, 32'h11223344, 0,  2, 32'h3FC,      4'h0, 32'h0,        32'h400,      4'h0, 32'h0,        2, 2, rsp(1,0,0,32'h0)));
    vecs.push_back(mk("trap_ld_w",    1, 32'h101,      32'h0,        W_W, 0, 1, 0, 32'h0,        32'h0,        0,  0, 32'h0,        4'h0, 32'h0,        32'h0,        4'h0, 32'h0,        0, 0, rsp(0,1,0,32'h0)));
    vecs.push_back(mk("trap_st_h",    1, 32'h303,      32'hCAFE,     W_H, 0, 0, 1, 32'h0,        32'h0,        0,  0, 32'h0,        4'h0, 32'h0,        32'h0,        4'h0, 32'h0,        0, 0, rsp(0,0,1,32'h0)));

    foreach (vecs[i]) run_vec(vecs[i]);

    // Non-memory instruction: no stall, no bus traffic, no response.
    @(posedge clk); #1;
    use_trap = 1'b0; ex_read = 1'b0; ex_write = 1'b0; ex_addr = 32'h104; ex_valid = 1'b1;
    #1 chk("nonmem_stall", 64'(d_stall), 64'(0));
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk("nonmem_idle", 64'({d_req, d_valid}), 64'(0));
    end
    ex_valid = 1'b0;

    // Reset while BEAT0 is outstanding: req drops at once, no response later.
    @(posedge clk); #1;
    ex_addr = 32'h900; ex_width = W_W; ex_read = 1'b1; ex_write = 1'b0; ex_valid = 1'b1;
    @(posedge clk); #1;
    chk("rstmid_req_before", 64'(d_req), 64'(1));
    #2 ex_valid = 1'b0; rst = 1'b1;
    #1 chk("rstmid_req_async", 64'(d_req), 64'(0));
    chk("rstmid_valid_async", 64'(d_valid), 64'(0));
    @(posedge clk); #1 rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      chk("rstmid_no_resp", 64'({d_valid, d_req}), 64'(0));
    end

    chk("scoreboard_empty", 64'(exp_q.size()), 64'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
